// File: rtl/sdram_pkg.sv
// rtl/sdram_pkg.sv - shared SDRAM command encodings, arbiter state type and refresh default
package sdram_pkg;

    // {cs_n, ras_n, cas_n, we_n}
    localparam logic [3:0] CMD_NOP       = 4'b0111;
    localparam logic [3:0] CMD_PRECHARGE = 4'b0010;
    localparam logic [3:0] CMD_AREF      = 4'b0001;
    localparam logic [3:0] CMD_MODE_REG  = 4'b0000;
    localparam logic [3:0] CMD_ACTIVE    = 4'b0011;
    localparam logic [3:0] CMD_WRITE     = 4'b0100;
    localparam logic [3:0] CMD_READ      = 4'b0101;

    // 7.8 us at a 20 MHz sclk
    localparam int AREF_PERIOD_DEF = 156;

    typedef enum logic [2:0] {
        ST_INIT  = 3'd0,
        ST_ARBIT = 3'd1,
        ST_AREF  = 3'd2,
        ST_WRITE = 3'd3,
        ST_READ  = 3'd4
    } arb_state_t;

endpackage

// File: rtl/sdram_aref_timer.sv
// rtl/sdram_aref_timer.sv - free-running refresh interval counter with sticky aref_pending
module sdram_aref_timer
    import sdram_pkg::*;
#(
    parameter int AREF_PERIOD = AREF_PERIOD_DEF
) (
    input  logic sclk,
    input  logic snrst,
    input  logic init_done,
    input  logic aref_clear,
    output logic aref_pending
);

    localparam int CW = (AREF_PERIOD > 1) ? $clog2(AREF_PERIOD) : 1;

    logic [CW-1:0] cnt_q;
    logic          started_q;
    logic          pending_q;
    logic          run;
    logic          wrap;

    // once init has been seen the counter never stops, even if init_done drops
    assign run  = started_q | init_done;
    assign wrap = (cnt_q == CW'(AREF_PERIOD - 1));

    always_ff @(posedge sclk or negedge snrst) begin
        if (!snrst) begin
            cnt_q     <= '0;
            started_q <= 1'b0;
            pending_q <= 1'b0;
        end else begin
            started_q <= run;
            if (run) begin
                cnt_q <= wrap ? '0 : cnt_q + CW'(1);
            end
            // a new deadline arriving on the grant edge must not be lost
            if (run && wrap) begin
                pending_q <= 1'b1;
            end else if (aref_clear) begin
                pending_q <= 1'b0;
            end
        end
    end

    assign aref_pending = pending_q;

endmodule

// File: rtl/sdram_arbiter.sv
// rtl/sdram_arbiter.sv - SDRAM command arbiter between init, refresh, write and read sequencers
module sdram_arbiter
    import sdram_pkg::*;
#(
    parameter int         AREF_PERIOD = AREF_PERIOD_DEF,
    parameter logic [3:0] NOP_CMD     = CMD_NOP
) (
    input  logic        sclk,
    input  logic        snrst,
    input  logic        init_done,
    input  logic [3:0]  init_cmd,
    input  logic [12:0] init_addr,
    input  logic [3:0]  aref_cmd,
    input  logic [12:0] aref_addr,
    input  logic        aref_end,
    input  logic        wr_req,
    input  logic        wr_end,
    input  logic [3:0]  wr_cmd,
    input  logic [12:0] wr_addr,
    input  logic [1:0]  wr_bank,
    input  logic        rd_req,
    input  logic        rd_end,
    input  logic [3:0]  rd_cmd,
    input  logic [12:0] rd_addr,
    input  logic [1:0]  rd_bank,
    output logic        aref_en,
    output logic        wr_en,
    output logic        rd_en,
    output logic [3:0]  sdram_cmd,
    output logic [12:0] sdram_addr,
    output logic [1:0]  sdram_bank
);

    arb_state_t state_q;
    logic       aref_en_q;
    logic       wr_en_q;
    logic       rd_en_q;
    logic       aref_pending;
    logic       aref_grant;

    assign aref_grant = (state_q == ST_ARBIT) && aref_pending;

    sdram_aref_timer #(
        .AREF_PERIOD(AREF_PERIOD)
    ) u_aref_timer (
        .sclk        (sclk),
        .snrst       (snrst),
        .init_done   (init_done),
        .aref_clear  (aref_grant),
        .aref_pending(aref_pending)
    );

    // every grant state exits only through ARBIT, which guarantees the NOP gap
    always_ff @(posedge sclk or negedge snrst) begin
        if (!snrst) begin
            state_q   <= ST_INIT;
            aref_en_q <= 1'b0;
            wr_en_q   <= 1'b0;
            rd_en_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_INIT: begin
                    if (init_done) state_q <= ST_ARBIT;
                end
                ST_ARBIT: begin
                    if (aref_pending) begin
                        state_q   <= ST_AREF;
                        aref_en_q <= 1'b1;
                    end else if (wr_req) begin
                        state_q <= ST_WRITE;
                        wr_en_q <= 1'b1;
                    end else if (rd_req) begin
                        state_q <= ST_READ;
                        rd_en_q <= 1'b1;
                    end
                end
                ST_AREF: begin
                    if (aref_end) begin
                        state_q   <= ST_ARBIT;
                        aref_en_q <= 1'b0;
                    end
                end
                ST_WRITE: begin
                    if (wr_end) begin
                        state_q <= ST_ARBIT;
                        wr_en_q <= 1'b0;
                    end
                end
                ST_READ: begin
                    if (rd_end) begin
                        state_q <= ST_ARBIT;
                        rd_en_q <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= ST_INIT;
                    aref_en_q <= 1'b0;
                    wr_en_q   <= 1'b0;
                    rd_en_q   <= 1'b0;
                end
            endcase
        end
    end

    assign aref_en = aref_en_q;
    assign wr_en   = wr_en_q;
    assign rd_en   = rd_en_q;

    always_comb begin
        sdram_cmd  = NOP_CMD;
        sdram_addr = 13'h0000;
        sdram_bank = 2'b00;
        case (state_q)
            ST_INIT: begin
                sdram_cmd  = init_cmd;
                sdram_addr = init_addr;
            end
            ST_AREF: begin
                sdram_cmd  = aref_cmd;
                sdram_addr = aref_addr;
            end
            ST_WRITE: begin
                sdram_cmd  = wr_cmd;
                sdram_addr = wr_addr;
                sdram_bank = wr_bank;
            end
            ST_READ: begin
                sdram_cmd  = rd_cmd;
                sdram_addr = rd_addr;
                sdram_bank = rd_bank;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_sdram_arbiter.sv
// tb/tb_sdram_arbiter.sv - randomized self-checking bench for sdram_arbiter against an owner/deadline model
module tb_sdram_arbiter;

    localparam int O_INIT = 0;
    localparam int O_IDLE = 1;
    localparam int O_AREF = 2;
    localparam int O_WR   = 3;
    localparam int O_RD   = 4;

    logic        sclk = 1'b0;
    logic        snrst = 1'b0;
    logic        init_done = 1'b0;
    logic [3:0]  init_cmd = 4'h0, aref_cmd = 4'h1, wr_cmd = 4'h4, rd_cmd = 4'h5;
    logic [12:0] init_addr = '0, aref_addr = '0, wr_addr = '0, rd_addr = '0;
    logic [1:0]  wr_bank = '0, rd_bank = '0;
    logic        aref_end = 1'b0, wr_end = 1'b0, rd_end = 1'b0;
    logic        wr_req = 1'b0, rd_req = 1'b0;

    logic        o_aref [2];
    logic        o_wr   [2];
    logic        o_rd   [2];
    logic [3:0]  o_cmd  [2];
    logic [12:0] o_addr [2];
    logic [1:0]  o_bank [2];

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    int m_owner [2];
    int m_tick  [2];
    bit m_start [2];
    bit m_pend  [2];
    int m_prevg [2];
    int per     [2] = '{156, 4};

    always #25 sclk = ~sclk;

    sdram_arbiter #(.AREF_PERIOD(156)) u_dut0 (
        .sclk(sclk), .snrst(snrst), .init_done(init_done),
        .init_cmd(init_cmd), .init_addr(init_addr),
        .aref_cmd(aref_cmd), .aref_addr(aref_addr), .aref_end(aref_end),
        .wr_req(wr_req), .wr_end(wr_end), .wr_cmd(wr_cmd), .wr_addr(wr_addr), .wr_bank(wr_bank),
        .rd_req(rd_req), .rd_end(rd_end), .rd_cmd(rd_cmd), .rd_addr(rd_addr), .rd_bank(rd_bank),
        .aref_en(o_aref[0]), .wr_en(o_wr[0]), .rd_en(o_rd[0]),
        .sdram_cmd(o_cmd[0]), .sdram_addr(o_addr[0]), .sdram_bank(o_bank[0])
    );

    sdram_arbiter #(.AREF_PERIOD(4)) u_dut1 (
        .sclk(sclk), .snrst(snrst), .init_done(init_done),
        .init_cmd(init_cmd), .init_addr(init_addr),
        .aref_cmd(aref_cmd), .aref_addr(aref_addr), .aref_end(aref_end),
        .wr_req(wr_req), .wr_end(wr_end), .wr_cmd(wr_cmd), .wr_addr(wr_addr), .wr_bank(wr_bank),
        .rd_req(rd_req), .rd_end(rd_end), .rd_cmd(rd_cmd), .rd_addr(rd_addr), .rd_bank(rd_bank),
        .aref_en(o_aref[1]), .wr_en(o_wr[1]), .rd_en(o_rd[1]),
        .sdram_cmd(o_cmd[1]), .sdram_addr(o_addr[1]), .sdram_bank(o_bank[1])
    );

    task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s dut%0d cyc=%0d observed=%0h expected=%0h", tag, k, cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_owner[k] = O_INIT;
            m_tick[k]  = 0;
            m_start[k] = 1'b0;
            m_pend[k]  = 1'b0;
            m_prevg[k] = 0;
        end
    endtask

    // refresh deadlines fall on every per-th counted edge after init
    task automatic model_edge(input int k, input bit rst, input bit idn, input bit aend,
                              input bit wreq, input bit wend, input bit rreq, input bit rend);
        bit counted, due, enter;
        if (!rst) return;
        counted = m_start[k] || idn;
        due     = counted && ((m_tick[k] % per[k]) == per[k] - 1);
        enter   = (m_owner[k] == O_IDLE) && m_pend[k];
        case (m_owner[k])
            O_INIT: if (idn) m_owner[k] = O_IDLE;
            O_IDLE: begin
                if (m_pend[k])  m_owner[k] = O_AREF;
                else if (wreq)  m_owner[k] = O_WR;
                else if (rreq)  m_owner[k] = O_RD;
            end
            O_AREF: if (aend) m_owner[k] = O_IDLE;
            O_WR:   if (wend) m_owner[k] = O_IDLE;
            O_RD:   if (rend) m_owner[k] = O_IDLE;
            default: ;
        endcase
        if (due)        m_pend[k] = 1'b1;
        else if (enter) m_pend[k] = 1'b0;
        if (counted) m_tick[k]++;
        m_start[k] = counted;
    endtask

    task automatic check_all();
        logic [3:0]  ecmd;
        logic [12:0] eaddr;
        logic [1:0]  ebank;
        int g;
        for (int k = 0; k < 2; k++) begin
            ecmd = 4'b0111; eaddr = '0; ebank = '0;
            case (m_owner[k])
                O_INIT: begin ecmd = init_cmd; eaddr = init_addr; end
                O_AREF: begin ecmd = aref_cmd; eaddr = aref_addr; end
                O_WR:   begin ecmd = wr_cmd;   eaddr = wr_addr; ebank = wr_bank; end
                O_RD:   begin ecmd = rd_cmd;   eaddr = rd_addr; ebank = rd_bank; end
                default: ;
            endcase
            chk("aref_en", k, 32'(o_aref[k]), 32'(m_owner[k] == O_AREF));
            chk("wr_en",   k, 32'(o_wr[k]),   32'(m_owner[k] == O_WR));
            chk("rd_en",   k, 32'(o_rd[k]),   32'(m_owner[k] == O_RD));
            chk("cmd",     k, 32'(o_cmd[k]),  32'(ecmd));
            chk("addr",    k, 32'(o_addr[k]), 32'(eaddr));
            chk("bank",    k, 32'(o_bank[k]), 32'(ebank));
            g = (o_aref[k] === 1'b1 ? 1 : 0) | (o_wr[k] === 1'b1 ? 2 : 0) | (o_rd[k] === 1'b1 ? 4 : 0);
            chk("onehot", k, 32'($countones(g) <= 1), 32'd1);
            chk("nop_gap", k, 32'(m_prevg[k] != 0 && g != 0 && g != m_prevg[k]), 32'd0);
            m_prevg[k] = g;
        end
    endtask

    task automatic step();
        bit rst, idn, aend, wreq, wend, rreq, rend;
        rst = snrst; idn = init_done; aend = aref_end;
        wreq = wr_req; wend = wr_end; rreq = rd_req; rend = rd_end;
        @(posedge sclk);
        cyc++;
        for (int k = 0; k < 2; k++) model_edge(k, rst, idn, aend, wreq, wend, rreq, rend);
        #1;
        check_all();
    endtask

    task automatic rand_data();
        init_cmd  = 4'($urandom); init_addr = 13'($urandom);
        aref_cmd  = 4'($urandom); aref_addr = 13'($urandom);
        wr_cmd    = 4'($urandom); wr_addr   = 13'($urandom); wr_bank = 2'($urandom);
        rd_cmd    = 4'($urandom); rd_addr   = 13'($urandom); rd_bank = 2'($urandom);
    endtask

    task automatic rand_ctrl();
        wr_req    = ($urandom % 3) == 0;
        rd_req    = ($urandom % 3) == 0;
        aref_end  = ($urandom % 3) == 0;
        wr_end    = ($urandom % 5) == 0;
        rd_end    = ($urandom % 5) == 0;
        init_done = ($urandom % 8) != 0;
    endtask

    initial begin
        int init_edge;
        int first_aref;
        model_reset();
        rand_data();
        #1;
        check_all();
        for (int i = 0; i < 3; i++) begin step(); rand_data(); end

        snrst = 1'b1;
        for (int i = 0; i < 6; i++) begin step(); rand_data(); end
        init_done = 1'b1;
        init_edge = cyc + 1;
        step();
        chk("arbit_after_init", 0, 32'(o_cmd[0]), 32'h7);

        // no requests: the first refresh on the default period is exactly 156 edges after init
        first_aref = -1;
        for (int i = 0; i < 200 && first_aref < 0; i++) begin
            aref_end = ($urandom % 3) == 0;
            rand_data();
            step();
            if (o_aref[0] === 1'b1) first_aref = cyc;
        end
        chk("first_aref_delay", 0, 32'(first_aref - init_edge), 32'd156);

        for (int i = 0; i < 1500; i++) begin
            rand_ctrl();
            rand_data();
            step();
        end

        // park dut0 in WRITE, then abort it with an asynchronous reset pulse
        init_done = 1'b1; wr_req = 1'b1; rd_req = 1'b0;
        wr_end = 1'b0; aref_end = 1'b1; rd_end = 1'b1;
        begin
            int n;
            n = 0;
            while (o_wr[0] !== 1'b1 && n < 400) begin step(); n++; end
            chk("reach_write", 0, 32'(o_wr[0]), 32'd1);
        end
        #10;
        snrst = 1'b0;
        model_reset();
        #1;
        check_all();
        init_cmd = ~init_cmd; init_addr = ~init_addr;
        #1;
        check_all();
        step();
        snrst = 1'b1; wr_req = 1'b0;
        step();
        chk("arbit_after_reset", 0, 32'(o_cmd[0]), 32'h7);

        for (int i = 0; i < 400; i++) begin
            rand_ctrl();
            rand_data();
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
